// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch front end: sequential word fetch over req/ack into a small {pc,instr} FIFO.
// Define STATIC_JUMP_PREDECODE_EN to follow j-format targets at fetch time and flag them on out_jpred.
module instr_prefetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_jpred
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [31:0]   fetch_pc;
    logic          stale;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;

    logic [31:0]   pc_q    [DEPTH];
    logic [31:0]   instr_q [DEPTH];
    logic          jpred_q [DEPTH];

    logic          ack;
    logic          push;
    logic          pop;
    logic          push_jpred;
    logic          outstanding_next;
    logic          req_next;
    logic [31:0]   addr_plus4;
    logic [31:0]   ack_target;
    logic [31:0]   next_pc;
    logic [CW-1:0] count_next;

    assign out_valid = (count != '0);
    assign out_instr = out_valid ? instr_q[rptr] : 32'd0;
    assign out_pc    = out_valid ? pc_q[rptr]    : 32'd0;
    assign out_jpred = out_valid ? jpred_q[rptr] : 1'b0;

    // A redirect discards both the returning word and any pop in the same cycle.
    always_comb begin
        ack        = mem_req & mem_ack;
        push       = ack & ~stale & ~redirect_valid;
        pop        = out_valid & out_ready & ~redirect_valid;
        addr_plus4 = mem_addr + 32'd4;
        push_jpred = 1'b0;
        ack_target = addr_plus4;
`ifdef STATIC_JUMP_PREDECODE_EN
        if (mem_rdata[31:26] == 6'd2) begin
            push_jpred = 1'b1;
            ack_target = {addr_plus4[31:28], mem_rdata[25:0], 2'b00};
        end
`endif
        if (redirect_valid) begin
            next_pc = redirect_pc & ~32'd3;
        end else if (push) begin
            next_pc = ack_target;
        end else begin
            next_pc = fetch_pc;
        end

        if (redirect_valid) begin
            count_next = '0;
        end else begin
            count_next = count + CW'(push) - CW'(pop);
        end

        // Only issue when the word can be guaranteed a FIFO slot on return.
        outstanding_next = mem_req & ~mem_ack;
        req_next         = outstanding_next | (count_next < CW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC;
            stale    <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
        end else begin
            fetch_pc <= next_pc;
            mem_req  <= req_next;
            if (req_next && !outstanding_next) begin
                mem_addr <= next_pc;
            end

            // An issued request cannot be withdrawn, so its data is marked for discard.
            if (redirect_valid && outstanding_next) begin
                stale <= 1'b1;
            end else if (ack) begin
                stale <= 1'b0;
            end

            count <= count_next;
            if (redirect_valid) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (push) wptr <= wptr + 1'b1;
                if (pop)  rptr <= rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            pc_q[wptr]    <= mem_addr;
            instr_q[wptr] <= mem_rdata;
            jpred_q[wptr] <= push_jpred;
        end
    end

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Self-checking bench for instr_prefetch_unit: directed scenarios plus a randomized run
// checked against a queue-based model of the fetch stream.
module tb_instr_prefetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_jpred;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int ack_delay = 0;
    int ack_prob  = 100;
    int waited    = 0;
    bit resp_en   = 1'b0;
    bit jump_mode = 1'b0;

    always #5 clk = ~clk;

    instr_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'd0)) dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_jpred(out_jpred)
    );

    // Instruction memory contents; word 0x10 becomes "j 0x40" in jump mode.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (jump_mode && a == 32'h10) return {6'd2, 26'h40};
        return {6'h23, a[27:2] ^ 26'h15A5A5};
    endfunction

    task automatic respond();
        if (mem_req && resp_en) begin
            if (waited >= ack_delay && $urandom_range(0, 99) < ack_prob) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_word(mem_addr);
                waited    = 0;
            end else begin
                mem_ack = 1'b0;
                waited++;
            end
        end else begin
            mem_ack = 1'b0;
            waited  = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        respond();
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect_valid = 1'b0; out_ready = 1'b0; resp_en = 1'b0;
        ack_delay = 0; ack_prob = 100; jump_mode = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if ({mem_req, out_valid, out_jpred} !== 3'b000)
            $display("[TB] FAIL reset_flags: got %b want 000", {mem_req, out_valid, out_jpred});
        else pass_cnt++;
        total_cnt++;
        if (mem_addr !== 32'd0) $display("[TB] FAIL reset_addr: got %h want 0", mem_addr);
        else pass_cnt++;
        total_cnt++;
        if ({out_instr, out_pc} !== 64'd0) $display("[TB] FAIL reset_out: got %h/%h want 0/0", out_instr, out_pc);
        else pass_cnt++;
        rst = 1'b0;
        tick();
        total_cnt++;
        if (mem_req !== 1'b1 || mem_addr !== 32'd0)
            $display("[TB] FAIL first_req: got req=%b addr=%h want 1/0", mem_req, mem_addr);
        else pass_cnt++;
    endtask

    task automatic test_stream();
        do_reset();
        resp_en = 1'b1; out_ready = 1'b1; rst = 1'b0;
        tick();
        for (int k = 0; k < 12; k++) begin
            tick();
            total_cnt++;
            if (mem_addr !== 32'(4 * (k + 1)))
                $display("[TB] FAIL stream_addr: got %h want %h", mem_addr, 32'(4 * (k + 1)));
            else pass_cnt++;
            total_cnt++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_instr !== mem_word(32'(4 * k)))
                $display("[TB] FAIL stream_out: got v=%b pc=%h i=%h want 1/%h/%h",
                         out_valid, out_pc, out_instr, 32'(4 * k), mem_word(32'(4 * k)));
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        resp_en = 1'b1; out_ready = 1'b0; rst = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        total_cnt++;
        if (mem_req !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'd0)
            $display("[TB] FAIL full_stall: got req=%b v=%b pc=%h want 0/1/0", mem_req, out_valid, out_pc);
        else pass_cnt++;
        out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            tick();
            if (j == 0) begin
                total_cnt++;
                if (mem_req !== 1'b1 || mem_addr !== 32'd16)
                    $display("[TB] FAIL resume_addr: got req=%b addr=%h want 1/10", mem_req, mem_addr);
                else pass_cnt++;
            end
            total_cnt++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * (j + 1)) || out_instr !== mem_word(32'(4 * (j + 1))))
                $display("[TB] FAIL drain_out: got v=%b pc=%h want 1/%h", out_valid, out_pc, 32'(4 * (j + 1)));
            else pass_cnt++;
        end
    endtask

    task automatic test_redirect_stale();
        int n;
        do_reset();
        resp_en = 1'b1; ack_delay = 3; out_ready = 1'b1; rst = 1'b0;
        tick();
        for (n = 0; n < 40 && !(mem_req && mem_addr == 32'h8); n++) tick();
        total_cnt++;
        if (n >= 40) $display("[TB] FAIL reach_addr8: got addr=%h want 8", mem_addr);
        else pass_cnt++;
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        total_cnt++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h8 || out_valid !== 1'b0)
            $display("[TB] FAIL stale_hold: got req=%b addr=%h v=%b want 1/8/0", mem_req, mem_addr, out_valid);
        else pass_cnt++;
        for (n = 0; n < 10 && mem_addr == 32'h8; n++) begin
            total_cnt++;
            if (out_valid !== 1'b0) $display("[TB] FAIL stale_nopush: got v=%b want 0", out_valid);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100 || out_valid !== 1'b0)
            $display("[TB] FAIL stale_next: got req=%b addr=%h v=%b want 1/100/0", mem_req, mem_addr, out_valid);
        else pass_cnt++;
        for (n = 0; n < 10 && !out_valid; n++) tick();
        total_cnt++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== mem_word(32'h100))
            $display("[TB] FAIL redirect_first: got v=%b pc=%h want 1/100", out_valid, out_pc);
        else pass_cnt++;
    endtask

    task automatic test_redirect_ack_pop();
        do_reset();
        resp_en = 1'b1; out_ready = 1'b1; rst = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        total_cnt++;
        if ((out_valid && mem_req && mem_ack) !== 1'b1)
            $display("[TB] FAIL ackpop_setup: got v=%b req=%b ack=%b want 1/1/1", out_valid, mem_req, mem_ack);
        else pass_cnt++;
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        tick();
        redirect_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h200)
            $display("[TB] FAIL ackpop_redir: got v=%b req=%b addr=%h want 0/1/200", out_valid, mem_req, mem_addr);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_valid !== 1'b1 || out_pc !== 32'h200)
            $display("[TB] FAIL ackpop_first: got v=%b pc=%h want 1/200", out_valid, out_pc);
        else pass_cnt++;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        total_cnt++;
        if (mem_addr !== 32'd0 || out_pc !== 32'hFFFF_FFFC)
            $display("[TB] FAIL pc_wrap: got addr=%h pc=%h want 0/fffffffc", mem_addr, out_pc);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        resp_en = 1'b1; out_ready = 1'b0; rst = 1'b0;
        tick();
        tick();
        tick();
        resp_en = 1'b0; mem_ack = 1'b0;
        tick();
        total_cnt++;
        if (out_valid !== 1'b1 || out_pc !== 32'd0 || mem_req !== 1'b1 || mem_addr !== 32'h8)
            $display("[TB] FAIL midrst_setup: got v=%b pc=%h req=%b addr=%h want 1/0/1/8",
                     out_valid, out_pc, mem_req, mem_addr);
        else pass_cnt++;
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        total_cnt++;
        if (out_valid !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 32'd0)
            $display("[TB] FAIL midrst_state: got v=%b req=%b addr=%h want 0/0/0", out_valid, mem_req, mem_addr);
        else pass_cnt++;
        rst = 1'b0; resp_en = 1'b1; out_ready = 1'b1;
        tick();
        total_cnt++;
        if (mem_req !== 1'b1 || mem_addr !== 32'd0)
            $display("[TB] FAIL midrst_req: got req=%b addr=%h want 1/0", mem_req, mem_addr);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_valid !== 1'b1 || out_pc !== 32'd0 || out_instr !== mem_word(32'd0))
            $display("[TB] FAIL midrst_out: got v=%b pc=%h want 1/0", out_valid, out_pc);
        else pass_cnt++;
    endtask

    task automatic test_jump();
        int n;
        do_reset();
        jump_mode = 1'b1; resp_en = 1'b1; out_ready = 1'b1; rst = 1'b0;
        for (n = 0; n < 20 && !(out_valid && out_pc == 32'h10); n++) tick();
        total_cnt++;
        if (n >= 20) $display("[TB] FAIL jump_reach: got pc=%h want 10", out_pc);
        else pass_cnt++;
        total_cnt++;
        if (out_instr !== mem_word(32'h10)) $display("[TB] FAIL jump_instr: got %h want %h", out_instr, mem_word(32'h10));
        else pass_cnt++;
`ifdef STATIC_JUMP_PREDECODE_EN
        total_cnt++;
        if (out_jpred !== 1'b1 || mem_addr !== 32'h100)
            $display("[TB] FAIL jump_pred: got jp=%b addr=%h want 1/100", out_jpred, mem_addr);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_pc !== 32'h100) $display("[TB] FAIL jump_target: got %h want 100", out_pc);
        else pass_cnt++;
`else
        total_cnt++;
        if (out_jpred !== 1'b0 || mem_addr !== 32'h14)
            $display("[TB] FAIL jump_pred: got jp=%b addr=%h want 0/14", out_jpred, mem_addr);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_pc !== 32'h14) $display("[TB] FAIL jump_target: got %h want 14", out_pc);
        else pass_cnt++;
`endif
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        logic [31:0] exp_fetch;
        logic [31:0] pre_addr;
        logic [31:0] head;
        bit          stale_m;
        bit          ack_ev;
        bit          pop_ev;
        bit          pre_wait;
        do_reset();
        resp_en = 1'b1; ack_prob = 60; rst = 1'b0;
        exp_fetch = 32'd0; stale_m = 1'b0;
        tick();
        for (int c = 0; c < 600; c++) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 39) == 0);
            redirect_pc    = $urandom & 32'h0000_0FFF;
            ack_ev   = mem_req && mem_ack;
            pop_ev   = out_valid && out_ready;
            pre_wait = mem_req && !mem_ack;
            pre_addr = mem_addr;
            if (pop_ev) begin
                head = (q.size() != 0) ? q[0] : 32'hFFFF_FFFF;
                total_cnt++;
                if (q.size() == 0 || out_pc !== head || out_instr !== mem_word(head))
                    $display("[TB] FAIL rand_pop: got pc=%h i=%h want %h/%h", out_pc, out_instr, head, mem_word(head));
                else pass_cnt++;
            end
            if (redirect_valid) begin
                q.delete();
                exp_fetch = redirect_pc & ~32'd3;
                stale_m   = pre_wait;
            end else begin
                if (pop_ev && q.size() != 0) void'(q.pop_front());
                if (ack_ev) begin
                    if (stale_m) begin
                        stale_m = 1'b0;
                    end else begin
                        total_cnt++;
                        if (mem_addr !== exp_fetch)
                            $display("[TB] FAIL rand_addr: got %h want %h", mem_addr, exp_fetch);
                        else pass_cnt++;
                        q.push_back(exp_fetch);
                        exp_fetch = exp_fetch + 32'd4;
                    end
                end
            end
            tick();
            total_cnt++;
            if (out_valid !== (q.size() != 0))
                $display("[TB] FAIL rand_valid: got %b want %b", out_valid, q.size() != 0);
            else pass_cnt++;
            if (pre_wait) begin
                total_cnt++;
                if (mem_req !== 1'b1 || mem_addr !== pre_addr)
                    $display("[TB] FAIL rand_hold: got req=%b addr=%h want 1/%h", mem_req, mem_addr, pre_addr);
                else pass_cnt++;
            end
        end
        redirect_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_stale();
        test_redirect_ack_pop();
        test_reset_mid();
        test_jump();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] simulation timeout");
    end

endmodule
